// File: rtl/line_buffer3_pkg.sv
// Shared types and defaults for the median filter line buffer front end.
package line_buffer3_pkg;

  localparam int PIX_W          = 8;
  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;

  typedef logic [PIX_W-1:0] pixel_t;

  // FILL: first line of a frame, RUN: emitting columns, FLUSH: bottom-border line
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } lb_state_t;

endpackage

// File: rtl/line_buffer3_if.sv
// Pixel stream in, 3-pixel column stream out.
// Handshake: on both streams a transfer happens on a rising clk edge where
// valid and ready are both high; once valid rises, it and its payload hold
// until that transfer occurs. ready may depend on valid, valid never on ready.
interface line_buffer3_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_top;
  logic [DATA_WIDTH-1:0] m_mid;
  logic [DATA_WIDTH-1:0] m_bot;
  logic                  m_last_col;
  logic                  m_last_row;

  // Producer of pixels / consumer of columns
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_top, m_mid, m_bot, m_last_col, m_last_row
  );

  // The line buffer itself
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_top, m_mid, m_bot, m_last_col, m_last_row
  );
endinterface

// File: rtl/line_buffer3_line_ram.sv
// Single-port line memory: combinational read, synchronous write, same address.
module line_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; the old word stays visible on rdata until the edge
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/line_buffer3.sv
// Raster-to-column front end: keeps two previous lines and emits one vertical
// 3-pixel column per pixel position, centred one line behind the input.
module line_buffer3
  import line_buffer3_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_W,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic               clk,
  input  logic               rst,
  line_buffer3_if.slave      bus,
  output lb_state_t          dbg_state
);

  localparam int XW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);

  lb_state_t state, state_nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;

  // Combinational controls
  logic                  out_free;
  logic                  s_ready_c;
  logic                  in_xfer;
  logic                  step;
  logic                  load;
  logic                  x_wrap;
  logic [DATA_WIDTH-1:0] col_top, col_mid, col_bot;
  logic                  col_lr;

  // Output register
  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_top_q, m_mid_q, m_bot_q;
  logic                  m_last_col_q, m_last_row_q;

  assign x_wrap   = (x == X_LAST);
  assign out_free = !m_valid_q || bus.m_ready;

  // lb0 holds line y-1, lb1 holds line y-2; both shift on every input pixel
  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH), .AW(XW)) u_lb0 (
    .clk   (clk),
    .we    (in_xfer),
    .addr  (x),
    .wdata (bus.s_data),
    .rdata (lb0_rd)
  );

  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH), .AW(XW)) u_lb1 (
    .clk   (clk),
    .we    (in_xfer),
    .addr  (x),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Next-state: each phase ends on the x wrap of its line
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (step && x_wrap)                 state_nxt = RUN;
      RUN:     if (step && x_wrap && (y == Y_LAST)) state_nxt = FLUSH;
      FLUSH:   if (step && x_wrap)                 state_nxt = FILL;
      default:                                     state_nxt = FILL;
    endcase
  end

  // Output decode: handshake, counter step and the column to load
  always_comb begin
    s_ready_c = (state != FLUSH) && out_free;
    in_xfer   = bus.s_valid && s_ready_c;
    step      = 1'b0;
    load      = 1'b0;
    col_top   = lb1_rd;
    col_mid   = lb0_rd;
    col_bot   = bus.s_data;
    col_lr    = 1'b0;
    case (state)
      FILL: begin
        step = in_xfer;
      end
      RUN: begin
        step = in_xfer;
        load = in_xfer;
        // Top border: on the first centre row the missing line above is replicated
        if (y == Y_ONE) col_top = lb0_rd;
      end
      FLUSH: begin
        step    = out_free;
        load    = out_free;
        col_bot = lb0_rd;
        col_lr  = 1'b1;
      end
      default: ;
    endcase
  end

  // Raster counters; y parks on the last row while FLUSH replays it
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (x_wrap) begin
        x <= '0;
        if (state == FLUSH)                      y <= '0;
        else if (!((state == RUN) && (y == Y_LAST))) y <= y + Y_ONE;
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // Single-entry output register; reload and take can share a cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q    <= 1'b0;
      m_top_q      <= '0;
      m_mid_q      <= '0;
      m_bot_q      <= '0;
      m_last_col_q <= 1'b0;
      m_last_row_q <= 1'b0;
    end else if (load) begin
      m_valid_q    <= 1'b1;
      m_top_q      <= col_top;
      m_mid_q      <= col_mid;
      m_bot_q      <= col_bot;
      m_last_col_q <= x_wrap;
      m_last_row_q <= col_lr;
    end else if (bus.m_ready) begin
      m_valid_q    <= 1'b0;
    end
  end

  assign bus.s_ready    = s_ready_c;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_top      = m_top_q;
  assign bus.m_mid      = m_mid_q;
  assign bus.m_bot      = m_bot_q;
  assign bus.m_last_col = m_last_col_q;
  assign bus.m_last_row = m_last_row_q;
  assign dbg_state      = state;

endmodule
